keyboard_command_decoder: RTL and testbench

Consumes the 8-bit PS/2 scan-code stream produced by the keyboard front end and turns it into discrete Tetrix game commands. It sits between the keyboard front end and the game controller. It does four things: detects each new byte, tracks the E0 (extended) and F0 (break) prefixes, suppresses typematic auto-repeat, and queues commands in a small FIFO with a valid/ready handshake.

---
 rtl/keyboard_command_decoder.sv | 138 +++++++++++++
 tb/tb_keyboard_command_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/keyboard_command_decoder.sv
// PS/2 scan-code stream to Tetrix command decoder.
// Handles E0/F0 prefixes, typematic suppression and a show-ahead command FIFO.
module keyboard_command_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FIFO_AW        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keyCode,
    input  logic       cmdReady,
    output logic       cmdValid,
    output logic [2:0] cmdCode,
    output logic [5:0] keysHeld,
    output logic       overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [7:0] EXT_CODE = 8'hE0;
    localparam logic [7:0] BRK_CODE = 8'hF0;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t              state;
    state_t              stateNext;
    logic [7:0]          keyCodePrev;
    logic [CW-1:0]       toCnt;
    logic                accept;
    logic                timeout;
    logic                isExt;
    logic                isBrk;
    logic                keyByte;
    logic                hit;
    logic [2:0]          keyIdx;
    logic                push;
    logic                pop;
    logic                full;
    logic                wrEn;
    logic [2:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wrPtr;
    logic [FIFO_AW-1:0]  rdPtr;
    logic [FIFO_AW:0]    count;

    assign accept  = (keyCode != 8'h00) && (keyCodePrev == 8'h00);
    assign isExt   = (state == EXT) || (state == EXT_BRK);
    assign isBrk   = (state == BRK) || (state == EXT_BRK);
    assign timeout = (state != IDLE) && (toCnt == TO_LAST);

    // Prefixes accumulate: E0 adds the ext flag, F0 adds the break flag.
    always_comb begin
        stateNext = state;
        keyByte   = 1'b0;
        if (accept) begin
            if (keyCode == EXT_CODE) begin
                stateNext = isBrk ? EXT_BRK : EXT;
            end else if (keyCode == BRK_CODE) begin
                stateNext = isExt ? EXT_BRK : BRK;
            end else begin
                keyByte   = 1'b1;
                stateNext = IDLE;
            end
        end else if (timeout) begin
            stateNext = IDLE;
        end
    end

    always_comb begin
        hit    = 1'b0;
        keyIdx = 3'd0;
        if (keyByte) begin
            unique case ({isExt, keyCode})
                9'h16B: begin hit = 1'b1; keyIdx = 3'd0; end
                9'h174: begin hit = 1'b1; keyIdx = 3'd1; end
                9'h175: begin hit = 1'b1; keyIdx = 3'd2; end
                9'h172: begin hit = 1'b1; keyIdx = 3'd3; end
                9'h029: begin hit = 1'b1; keyIdx = 3'd4; end
                9'h04D: begin hit = 1'b1; keyIdx = 3'd5; end
                default: ;
            endcase
        end
    end

    assign push     = hit && !isBrk && !keysHeld[keyIdx];
    assign cmdValid = (count != '0);
    assign full     = (count == FULL_CNT);
    assign pop      = cmdValid && cmdReady;
    assign wrEn     = push && (!full || pop);
    assign cmdCode  = cmdValid ? mem[rdPtr] : 3'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keyCodePrev <= 8'h00;
            state       <= IDLE;
            toCnt       <= '0;
            keysHeld    <= 6'b0;
        end else begin
            keyCodePrev <= keyCode;
            state       <= stateNext;
            if (accept || timeout || state == IDLE) begin
                toCnt <= '0;
            end else begin
                toCnt <= toCnt + 1'b1;
            end
            if (hit) begin
                keysHeld[keyIdx] <= !isBrk;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 3'd0;
            end
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrEn) begin
                mem[wrPtr] <= keyIdx;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({wrEn, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow <= push && full && !pop;
        end
    end

endmodule

// File: tb/tb_keyboard_command_decoder.sv
// Table-driven directed bench for keyboard_command_decoder.
// Timeout shortened so the prefix-abandon cases run quickly.
module tb_keyboard_command_decoder;

    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] keyCode = 8'h00;
    logic       cmdReady = 1'b0;
    logic       cmdValid;
    logic [2:0] cmdCode;
    logic [5:0] keysHeld;
    logic       overflow;

    keyboard_command_decoder #(
        .TIMEOUT_CYCLES(TO),
        .FIFO_AW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .keyCode(keyCode),
        .cmdReady(cmdReady),
        .cmdValid(cmdValid),
        .cmdCode(cmdCode),
        .keysHeld(keysHeld),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] kc;
        logic       rdy;
        int         reps;
        bit         rstPulse;
        logic       v;
        logic [2:0] c;
        logic [5:0] h;
        logic       o;
    } vec_t;

    vec_t tbl[$];
    int nVec = 0;
    int nMis = 0;

    function automatic void add(input logic [7:0] kc, input logic rdy,
                                input int reps, input logic v,
                                input logic [2:0] c, input logic [5:0] h,
                                input logic o);
        vec_t e;
        e.kc = kc; e.rdy = rdy; e.reps = reps; e.rstPulse = 1'b0;
        e.v = v; e.c = c; e.h = h; e.o = o;
        tbl.push_back(e);
    endfunction

    function automatic void addRst(input logic [7:0] kc);
        vec_t e;
        e.kc = kc; e.rdy = 1'b0; e.reps = 1; e.rstPulse = 1'b1;
        e.v = 1'b0; e.c = 3'd0; e.h = 6'b0; e.o = 1'b0;
        tbl.push_back(e);
    endfunction

    task automatic check(input string nm, input vec_t e);
        nVec++;
        if ({cmdValid, cmdCode, keysHeld, overflow} !== {e.v, e.c, e.h, e.o}) begin
            nMis++;
            $display("FAIL %s: got valid=%0b code=%0d held=%b ovf=%0b, want valid=%0b code=%0d held=%b ovf=%0b",
                     nm, cmdValid, cmdCode, keysHeld, overflow, e.v, e.c, e.h, e.o);
        end
    endtask

    initial begin
        // reset state
        addRst(8'h00);
        // held 29 pushes once
        add(8'h29, 0, 100, 1, 4, 6'h10, 0);
        add(8'h00, 0, 1,   1, 4, 6'h10, 0);
        add(8'h00, 1, 1,   0, 0, 6'h10, 0);
        add(8'hF0, 0, 1,   0, 0, 6'h10, 0);
        add(8'h00, 0, 1,   0, 0, 6'h10, 0);
        add(8'h29, 0, 1,   0, 0, 6'h00, 0);
        add(8'h00, 0, 1,   0, 0, 6'h00, 0);
        // LEFT with typematic repeat, then break
        add(8'hE0, 1, 1, 0, 0, 6'h00, 0);
        add(8'h00, 1, 1, 0, 0, 6'h00, 0);
        add(8'h6B, 1, 1, 1, 0, 6'h01, 0);
        add(8'h00, 1, 1, 0, 0, 6'h01, 0);
        add(8'hE0, 1, 1, 0, 0, 6'h01, 0);
        add(8'h00, 1, 1, 0, 0, 6'h01, 0);
        add(8'h6B, 1, 1, 0, 0, 6'h01, 0);
        add(8'h00, 1, 1, 0, 0, 6'h01, 0);
        add(8'hE0, 1, 1, 0, 0, 6'h01, 0);
        add(8'h00, 1, 1, 0, 0, 6'h01, 0);
        add(8'hF0, 1, 1, 0, 0, 6'h01, 0);
        add(8'h00, 1, 1, 0, 0, 6'h01, 0);
        add(8'h6B, 1, 1, 0, 0, 6'h00, 0);
        add(8'h00, 1, 1, 0, 0, 6'h00, 0);
        // plain 6B ignored; E0 times out so 74 is ignored
        add(8'h6B, 1, 1,  0, 0, 6'h00, 0);
        add(8'h00, 1, 1,  0, 0, 6'h00, 0);
        add(8'hE0, 1, 1,  0, 0, 6'h00, 0);
        add(8'h00, 1, TO, 0, 0, 6'h00, 0);
        add(8'h74, 1, 1,  0, 0, 6'h00, 0);
        add(8'h00, 1, 1,  0, 0, 6'h00, 0);
        // one cycle short of the timeout: RIGHT still decodes
        add(8'hE0, 1, 1,    0, 0, 6'h00, 0);
        add(8'h00, 1, TO-1, 0, 0, 6'h00, 0);
        add(8'h74, 1, 1,    1, 1, 6'h02, 0);
        add(8'h00, 1, 1,    0, 0, 6'h02, 0);
        add(8'hE0, 1, 1,    0, 0, 6'h02, 0);
        add(8'h00, 1, 1,    0, 0, 6'h02, 0);
        add(8'hF0, 1, 1,    0, 0, 6'h02, 0);
        add(8'h00, 1, 1,    0, 0, 6'h02, 0);
        add(8'h74, 1, 1,    0, 0, 6'h00, 0);
        add(8'h00, 1, 1,    0, 0, 6'h00, 0);
        // fill the FIFO, fifth make overflows
        add(8'hE0, 0, 1, 0, 0, 6'h00, 0);
        add(8'h00, 0, 1, 0, 0, 6'h00, 0);
        add(8'h6B, 0, 1, 1, 0, 6'h01, 0);
        add(8'h00, 0, 1, 1, 0, 6'h01, 0);
        add(8'hE0, 0, 1, 1, 0, 6'h01, 0);
        add(8'h00, 0, 1, 1, 0, 6'h01, 0);
        add(8'h74, 0, 1, 1, 0, 6'h03, 0);
        add(8'h00, 0, 1, 1, 0, 6'h03, 0);
        add(8'hE0, 0, 1, 1, 0, 6'h03, 0);
        add(8'h00, 0, 1, 1, 0, 6'h03, 0);
        add(8'h75, 0, 1, 1, 0, 6'h07, 0);
        add(8'h00, 0, 1, 1, 0, 6'h07, 0);
        add(8'hE0, 0, 1, 1, 0, 6'h07, 0);
        add(8'h00, 0, 1, 1, 0, 6'h07, 0);
        add(8'h72, 0, 1, 1, 0, 6'h0F, 0);
        add(8'h00, 0, 1, 1, 0, 6'h0F, 0);
        add(8'h29, 0, 1, 1, 0, 6'h1F, 1);
        add(8'h00, 0, 1, 1, 0, 6'h1F, 0);
        // full FIFO: pop and push PAUSE on the same edge
        add(8'h4D, 1, 1, 1, 1, 6'h3F, 0);
        add(8'h00, 1, 1, 1, 2, 6'h3F, 0);
        add(8'h00, 1, 1, 1, 3, 6'h3F, 0);
        add(8'h00, 1, 1, 1, 5, 6'h3F, 0);
        add(8'h00, 1, 1, 0, 0, 6'h3F, 0);
        // clean slate, then reset in the middle of E0 F0
        addRst(8'h00);
        add(8'hE0, 0, 1, 0, 0, 6'h00, 0);
        add(8'h00, 0, 1, 0, 0, 6'h00, 0);
        add(8'h6B, 0, 1, 1, 0, 6'h01, 0);
        add(8'h00, 0, 1, 1, 0, 6'h01, 0);
        add(8'hE0, 0, 1, 1, 0, 6'h01, 0);
        add(8'h00, 0, 1, 1, 0, 6'h01, 0);
        add(8'h74, 0, 1, 1, 0, 6'h03, 0);
        add(8'h00, 0, 1, 1, 0, 6'h03, 0);
        add(8'hE0, 0, 1, 1, 0, 6'h03, 0);
        add(8'h00, 0, 1, 1, 0, 6'h03, 0);
        add(8'hF0, 0, 1, 1, 0, 6'h03, 0);
        addRst(8'h6B);
        // 6B present at the first edge after release is plain, no command
        add(8'h6B, 0, 1, 0, 0, 6'h00, 0);
        add(8'h00, 0, 1, 0, 0, 6'h00, 0);
        add(8'h29, 0, 1, 1, 4, 6'h10, 0);

        foreach (tbl[i]) begin
            keyCode  = tbl[i].kc;
            cmdReady = tbl[i].rdy;
            if (tbl[i].rstPulse) begin
                #2;
                rst = 1'b0;
                #1;
                check($sformatf("reset%0d", i), tbl[i]);
                @(posedge clk);
                #1;
                rst = 1'b1;
            end else begin
                for (int r = 0; r < tbl[i].reps; r++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("vec%0d.%0d", i, r), tbl[i]);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
